// File: rtl/bcd_to_bin_unit.sv
// bcd_to_bin_unit
//   Sequential packed-BCD to binary converter. Consumes one BCD digit per
//   ready-qualified clock, most significant digit first, accumulating
//   acc = acc*10 + digit. The result is truncated modulo 2^BIN_W.
//
//   Optional feature macro: BCD_CHECK_EN
//     defined   -> invalid reports whether any consumed digit was > 9
//     undefined -> no check logic, invalid tied to 0
//
// Ports
//   clk      core clock, all state changes on posedge
//   reset    synchronous active-high reset (priority over ready/start)
//   ready    global stall; 0 = every register holds
//   start    request conversion of bcd_in, honoured only when idle
//   bcd_in   packed BCD operand, digit DIGITS-1 in the MS nibble
//   busy     conversion in progress
//   done     one-cycle (ready-qualified) pulse, bin_out valid
//   bin_out  converted value, held until the next completion
//   invalid  a digit > 9 was seen in the last completed conversion
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; done pulse from last conversion clears
// CONV  | one digit accumulated per ready edge, down-counter tracks
//       | remaining digits, terminal count 1 completes
module bcd_to_bin_unit #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ready,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  invalid
);

    localparam int CNT_W = $clog2(DIGITS + 1);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t              state;
    logic [4*DIGITS-1:0] digit_sr;
    logic [BIN_W-1:0]    acc;
    logic [CNT_W-1:0]    cnt;

    logic [3:0]          cur_digit;
    logic [BIN_W-1:0]    acc_x10;
    logic [BIN_W-1:0]    next_acc;
    logic                last_digit;

    // acc*10 built from shifts; carries beyond BIN_W fall off by width.
    always_comb begin
        cur_digit  = digit_sr[4*DIGITS-1 -: 4];
        acc_x10    = (acc << 3) + (acc << 1);
        next_acc   = acc_x10 + BIN_W'(cur_digit);
        last_digit = (cnt == CNT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            bin_out  <= '0;
            acc      <= '0;
            cnt      <= '0;
            digit_sr <= '0;
        end else if (ready) begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        digit_sr <= bcd_in;
                        acc      <= '0;
                        cnt      <= CNT_W'(DIGITS);
                        busy     <= 1'b1;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    acc      <= next_acc;
                    digit_sr <= digit_sr << 4;
                    cnt      <= cnt - CNT_W'(1);
                    done     <= 1'b0;
                    if (last_digit) begin
                        bin_out <= next_acc;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BCD_CHECK_EN
    // Sticky flag for the conversion in flight; published with bin_out.
    logic inv_acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            inv_acc <= 1'b0;
            invalid <= 1'b0;
        end else if (ready) begin
            if (state == IDLE && start) begin
                inv_acc <= 1'b0;
            end else if (state == CONV) begin
                inv_acc <= inv_acc | (cur_digit > 4'd9);
                if (last_digit) begin
                    invalid <= inv_acc | (cur_digit > 4'd9);
                end
            end
        end
    end
`else
    assign invalid = 1'b0;
`endif

endmodule
